dct_wr_tbuf: RTL and testbench

- Ping-pong transpose buffer directly upstream of the write DMA in the 4x4 2D-DCT accelerator.
- Accepts the DCT core's output one column per beat (4 coefficients) and reorders each 4x4 block to row-major.
- Emits one row per beat on the DMA's wr_en/full_n/din stream interface.
- Two banks let one block fill while the previous block drains, sustaining 1 word/cycle.

---
 rtl/dct_pkg.sv | 29 ++
 rtl/dct_tbuf_bank.sv | 47 ++++
 rtl/dct_wr_tbuf.sv | 116 +++++++++++
 tb/tb_dct_wr_tbuf.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dct_pkg: shared constants, bank-state encoding and coefficient slice  |
// | helper for the 4x4 DCT write-side transpose buffer.                   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package dct_pkg;

    localparam int COEF_W = 16;
    localparam int N      = 4;
    localparam int DATA_W = N * COEF_W;
    localparam int IDX_W  = $clog2(N);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'b00,
        BANK_FILLING = 2'b01,
        BANK_FULL    = 2'b10
    } bank_state_t;

    // Coefficient idx of a packed beat (row of a column beat, or column of a row).
    function automatic logic [COEF_W-1:0] coef_slice(
        input logic [DATA_W-1:0] word,
        input logic [IDX_W-1:0]  idx
    );
        return word[COEF_W*idx +: COEF_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct_tbuf_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dct_tbuf_bank: one N x N coefficient bank, column write / row read.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dct_tbuf_bank
    import dct_pkg::*;
(
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              clear,
    input  logic              we,
    input  logic [IDX_W-1:0]  col_idx,
    input  logic [DATA_W-1:0] col_data,
    input  logic [IDX_W-1:0]  row_idx,
    output logic [DATA_W-1:0] row_data
);

    // Indexed [row][col].
    logic [COEF_W-1:0] r_mem [N][N];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (clear) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (we) begin
            for (int r = 0; r < N; r++) begin
                r_mem[r][col_idx] <= coef_slice(col_data, IDX_W'(r));
            end
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_row
        assign row_data[COEF_W*c +: COEF_W] = r_mem[row_idx][c];
    end

endmodule
`default_nettype wire

// File: rtl/dct_wr_tbuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dct_wr_tbuf: ping-pong 4x4 transpose buffer, column beats in,         |
// | row-major words out to the write DMA.                                 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dct_wr_tbuf #(
    parameter int COEF_W = 16,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_wr_en,
    input  logic              m_full_n,
    output logic [DATA_W-1:0] m_dout,
    output logic [CNT_W-1:0]  blk_done_cnt,
    output logic              busy
);

    import dct_pkg::*;

    if (DATA_W != N * COEF_W || COEF_W != dct_pkg::COEF_W) begin : g_width_check
        $error("dct_wr_tbuf: DATA_W must equal N*COEF_W = %0d", N * dct_pkg::COEF_W);
    end

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

    logic              r_init_done;
    bank_state_t       r_state [2];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [CNT_W-1:0]  r_blk_cnt;

    logic              w_s_hs;
    logic              w_m_hs;
    logic              w_bank_we [2];
    logic [DATA_W-1:0] w_row     [2];

    // r_init_done keeps s_ready low until the first edge out of reset.
    assign s_ready      = r_init_done && (r_state[r_wr_bank] != BANK_FULL);
    assign m_wr_en      = (r_state[r_rd_bank] == BANK_FULL);
    assign m_dout       = m_wr_en ? w_row[r_rd_bank] : '0;
    assign blk_done_cnt = r_blk_cnt;
    assign busy         = (r_state[0] != BANK_EMPTY) || (r_state[1] != BANK_EMPTY);

    assign w_s_hs = s_valid && s_ready;
    assign w_m_hs = m_wr_en && m_full_n;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_bank_we[b] = w_s_hs && !clear && (r_wr_bank == 1'(b));

        dct_tbuf_bank u_bank (
            .ap_clk   (ap_clk),
            .ap_rst   (ap_rst),
            .clear    (clear),
            .we       (w_bank_we[b]),
            .col_idx  (r_wr_idx),
            .col_data (s_data),
            .row_idx  (r_rd_idx),
            .row_data (w_row[b])
        );
    end

    // A write only targets a non-FULL bank and a read only a FULL one, so the
    // two updates below never touch the same bank state in one cycle.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_init_done <= 1'b0;
            r_state[0]  <= BANK_EMPTY;
            r_state[1]  <= BANK_EMPTY;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_blk_cnt   <= '0;
        end else begin
            r_init_done <= 1'b1;
            if (clear) begin
                r_state[0] <= BANK_EMPTY;
                r_state[1] <= BANK_EMPTY;
                r_wr_bank  <= 1'b0;
                r_rd_bank  <= 1'b0;
                r_wr_idx   <= '0;
                r_rd_idx   <= '0;
                r_blk_cnt  <= '0;
            end else begin
                if (w_s_hs) begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                    if (r_wr_idx == c_last_idx) begin
                        r_state[r_wr_bank] <= BANK_FULL;
                        r_wr_bank          <= ~r_wr_bank;
                    end else begin
                        r_state[r_wr_bank] <= BANK_FILLING;
                    end
                end
                if (w_m_hs) begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                    if (r_rd_idx == c_last_idx) begin
                        r_state[r_rd_bank] <= BANK_EMPTY;
                        r_rd_bank          <= ~r_rd_bank;
                        r_blk_cnt          <= r_blk_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct_wr_tbuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dct_wr_tbuf: directed and random stimulus against a queue-based    |
// | transpose model of dct_wr_tbuf.                                       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_dct_wr_tbuf;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_wr_en;
    logic        m_full_n;
    logic [63:0] m_dout;
    logic [15:0] blk_done_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    dct_wr_tbuf #(.COEF_W(16), .DATA_W(64), .CNT_W(16)) dut (
        .ap_clk       (clk),
        .ap_rst       (rst),
        .clear        (clear),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_wr_en      (m_wr_en),
        .m_full_n     (m_full_n),
        .m_dout       (m_dout),
        .blk_done_cnt (blk_done_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // coef(r,c) = base + r*256 + c, packed as a column beat.
    function automatic logic [63:0] mkcol(input logic [15:0] base, input int c);
        logic [63:0] w;
        for (int r = 0; r < 4; r++) begin
            w[16*r +: 16] = base + 16'(r * 256) + 16'(c);
        end
        return w;
    endfunction

    // ---------------- reference model ----------------
    logic [63:0] exp_q  [$];
    logic [63:0] part_q [$];
    int          exp_done  = 0;
    bit          init_done = 0;
    int          held;
    bit          e_ready;
    bit          e_wr;
    logic [63:0] row;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_m_wr_en", 64'(m_wr_en), 64'd0);
            chk("rst_m_dout", m_dout, 64'd0);
            chk("rst_blk_done_cnt", 64'(blk_done_cnt), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            exp_q.delete();
            part_q.delete();
            exp_done  = 0;
            init_done = 0;
        end else begin
            held    = (exp_q.size() + 3) / 4;
            e_ready = init_done && (held < 2);
            e_wr    = (held > 0);
            chk("s_ready", 64'(s_ready), 64'(e_ready));
            chk("m_wr_en", 64'(m_wr_en), 64'(e_wr));
            chk("busy", 64'(busy), 64'((held > 0) || (part_q.size() > 0)));
            chk("blk_done_cnt", 64'(blk_done_cnt), 64'(exp_done[15:0]));
            if (e_wr) chk("m_dout", m_dout, exp_q[0]);
            if (clear) begin
                exp_q.delete();
                part_q.delete();
                exp_done = 0;
            end else begin
                if (e_wr && m_full_n) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() % 4 == 0) exp_done++;
                end
                if (e_ready && s_valid) begin
                    part_q.push_back(s_data);
                    if (part_q.size() == 4) begin
                        for (int r = 0; r < 4; r++) begin
                            for (int c = 0; c < 4; c++) begin
                                row[16*c +: 16] = part_q[c][16*r +: 16];
                            end
                            exp_q.push_back(row);
                        end
                        part_q.delete();
                    end
                end
            end
            init_done = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_col(input logic [63:0] d);
        int  n;
        bit  hs;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        forever begin
            @(negedge clk);
            hs = s_ready;
            step();
            if (hs) break;
            n++;
            if (n > 2000) begin
                chk("send_timeout", 64'(n), 64'd0);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            step();
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    int  b2b_cyc, b2b_first, b2b_last, b2b_nout, b2b_nin, b2b_drops;
    bit  stop_rand;

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_full_n = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        step();
        chk("ready_after_reset", 64'(s_ready), 64'd1);

        // Single block, sink always ready.
        for (int c = 0; c < 4; c++) send_col(mkcol(16'h0000, c));
        chk("blk1_wr_en", 64'(m_wr_en), 64'd1);
        chk("blk1_row0", m_dout, 64'h0003_0002_0001_0000);
        step();
        chk("blk1_row1", m_dout, 64'h0103_0102_0101_0100);
        step();
        step();
        chk("blk1_row3", m_dout, 64'h0303_0302_0301_0300);
        step();
        chk("blk1_done_cnt", 64'(blk_done_cnt), 64'd1);
        chk("blk1_wr_en_low", 64'(m_wr_en), 64'd0);

        // Back-to-back 8 blocks.
        do_clear();
        b2b_cyc = 0; b2b_first = -1; b2b_last = -1;
        b2b_nout = 0; b2b_nin = 0; b2b_drops = 0;
        fork
            begin
                for (int i = 0; i < 32; i++) send_col(mkcol(16'((i / 4) * 4096), i % 4));
            end
            begin
                while (b2b_nout < 32 && b2b_cyc < 100) begin
                    @(negedge clk);
                    if (b2b_nin >= 4 && b2b_nin < 32 && !s_ready) b2b_drops++;
                    if (s_valid && s_ready) b2b_nin++;
                    if (m_wr_en && m_full_n) begin
                        if (b2b_first < 0) b2b_first = b2b_cyc;
                        b2b_last = b2b_cyc;
                        b2b_nout++;
                    end
                    b2b_cyc++;
                end
            end
        join
        chk("b2b_words", 64'(b2b_nout), 64'd32);
        chk("b2b_span", 64'(b2b_last - b2b_first), 64'd31);
        chk("b2b_ready_drops", 64'(b2b_drops), 64'd0);
        step();
        chk("b2b_done_cnt", 64'(blk_done_cnt), 64'd8);

        // Backpressure: sink stalled, both banks fill.
        do_clear();
        m_full_n = 1'b0;
        for (int i = 0; i < 8; i++) send_col(mkcol(i < 4 ? 16'hA000 : 16'hB000, i % 4));
        chk("bp_ready_low", 64'(s_ready), 64'd0);
        s_valid = 1'b1;
        s_data  = mkcol(16'hD000, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_ready", 64'(s_ready), 64'd0);
            chk("bp_hold_row0", m_dout, 64'hA003_A002_A001_A000);
        end
        step();
        m_full_n = 1'b1;
        for (int c = 0; c < 4; c++) send_col(mkcol(16'hD000, c));
        wait_idle();
        chk("bp_done_cnt", 64'(blk_done_cnt), 64'd3);

        // Random valid / backpressure over 100 blocks.
        do_clear();
        stop_rand = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    while ($urandom_range(9) >= 7) step();
                    send_col({$urandom, $urandom});
                end
                wait_idle();
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    m_full_n = 1'($urandom_range(1));
                    step();
                end
            end
        join
        m_full_n = 1'b1;
        chk("rand_done_cnt", 64'(blk_done_cnt), 64'd100);

        // Clear while one block is half-drained and the next is half-filled.
        m_full_n = 1'b0;
        for (int c = 0; c < 4; c++) send_col(mkcol(16'h5000, c));
        send_col(mkcol(16'h6000, 0));
        send_col(mkcol(16'h6000, 1));
        m_full_n = 1'b1;
        step();
        step();
        m_full_n = 1'b0;
        chk("pre_clear_busy", 64'(busy), 64'd1);
        clear    = 1'b1;
        s_valid  = 1'b1;
        s_data   = mkcol(16'h6000, 2);
        m_full_n = 1'b1;
        step();
        clear   = 1'b0;
        s_valid = 1'b0;
        chk("clr_wr_en", 64'(m_wr_en), 64'd0);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done_cnt", 64'(blk_done_cnt), 64'd0);
        for (int c = 0; c < 4; c++) send_col(mkcol(16'hC000, c));
        chk("clr_next_row0", m_dout, 64'hC003_C002_C001_C000);
        wait_idle();
        chk("clr_next_done_cnt", 64'(blk_done_cnt), 64'd1);

        // Async reset mid-drain.
        for (int c = 0; c < 4; c++) send_col(mkcol(16'hE000, c));
        step();
        chk("pre_rst_wr_en", 64'(m_wr_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_en", 64'(m_wr_en), 64'd0);
        chk("arst_done_cnt", 64'(blk_done_cnt), 64'd0);
        chk("arst_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        chk("arst_ready_after", 64'(s_ready), 64'd1);
        for (int c = 0; c < 4; c++) send_col(mkcol(16'h1000, c));
        chk("arst_next_row0", m_dout, 64'h1003_1002_1001_1000);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
